img_stream_tx: RTL and testbench

Frame-stream transmitter that produces the raster pixel stream consumed by the window/line-buffer pipeline: `field_vld` framing, per-pixel `pixel_vld` and `DW`-bit data. Pixels are drawn from an upstream first-word-fall-through FIFO, which is typically fed by DDR readback. The block generates vertical and horizontal blanking, stalls cleanly when the FIFO runs dry, and guarantees exactly `IMAGE_WIDTH`×`IMAGE_HEIGHT` valid pixels per field.

---
 rtl/img_stream_tx.sv | 147 ++++++++++++++
 tb/tb_img_stream_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_tx.sv
// Raster field transmitter: VPRE/LINE/HBLANK/VPOST framing around pixels popped from a FWFT FIFO.
// Latency: pop in cycle N appears on o_pixel_vld/o_image_data at N+1; field_vld rises the cycle after i_start.
// Backpressure: an empty FIFO freezes the line (no pop, o_stall pulse); IMG_STREAM_TX_TEST_PATTERN_EN adds i_pattern_en.
module img_stream_tx #(
    parameter int DW           = 8,
    parameter int CW           = 10,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int H_BLANK      = 16,
    parameter int V_FRONT      = 4,
    parameter int V_BACK       = 4
) (
    input  logic          i_Sys_clk,
    input  logic          i_Rst_n,
    input  logic          i_start,
`ifdef IMG_STREAM_TX_TEST_PATTERN_EN
    input  logic          i_pattern_en,
`endif
    input  logic          i_fifo_empty,
    input  logic [DW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_field_vld,
    output logic          o_pixel_vld,
    output logic [DW-1:0] o_image_data,
    output logic          o_busy,
    output logic          o_stall
);

    localparam int MAXB_HV = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
    localparam int MAXB    = (MAXB_HV > V_BACK) ? MAXB_HV : V_BACK;
    localparam int BW      = (MAXB > 1) ? $clog2(MAXB) : 1;

    localparam logic [BW-1:0] VF_LOAD = BW'(V_FRONT - 1);
    localparam logic [BW-1:0] VB_LOAD = BW'(V_BACK - 1);
    localparam logic [BW-1:0] HB_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VPRE,
        S_LINE,
        S_HBLANK,
        S_VPOST
    } state_t;

    state_t          state;
    logic [BW-1:0]   blank_cnt;
    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic            pat_mode;
    logic            in_line;
    logic            take;
    logic [CW:0]     pat_sum;
    logic [DW-1:0]   pix_dat;

`ifdef IMG_STREAM_TX_TEST_PATTERN_EN
    assign pat_mode = i_pattern_en;
`else
    assign pat_mode = 1'b0;
`endif

    // A pattern-mode line never waits on the FIFO, so every LINE cycle yields a pixel.
    assign in_line   = (state == S_LINE);
    assign take      = in_line && (pat_mode || !i_fifo_empty);
    assign o_fifo_rd = in_line && !pat_mode && !i_fifo_empty;
    assign o_busy    = (state != S_IDLE);

    assign pat_sum = {1'b0, row} + {1'b0, col};
    assign pix_dat = pat_mode ? DW'(pat_sum) : i_fifo_data;

    always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= S_IDLE;
            blank_cnt    <= '0;
            col          <= '0;
            row          <= '0;
            o_field_vld  <= 1'b0;
            o_pixel_vld  <= 1'b0;
            o_image_data <= '0;
            o_stall      <= 1'b0;
        end else begin
            o_pixel_vld  <= take;
            o_image_data <= take ? pix_dat : '0;
            o_stall      <= in_line && !pat_mode && i_fifo_empty;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state       <= S_VPRE;
                        blank_cnt   <= VF_LOAD;
                        o_field_vld <= 1'b1;
                    end
                end
                S_VPRE: begin
                    if (blank_cnt == '0) begin
                        state <= S_LINE;
                        col   <= '0;
                        row   <= '0;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                S_LINE: begin
                    if (take) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                state     <= S_VPOST;
                                blank_cnt <= VB_LOAD;
                            end else begin
                                row <= row + 1'b1;
                                if (H_BLANK > 0) begin
                                    state     <= S_HBLANK;
                                    blank_cnt <= HB_LOAD;
                                end
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt == '0) begin
                        state <= S_LINE;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                S_VPOST: begin
                    // The following IDLE cycle guarantees at least one low cycle of field_vld.
                    if (blank_cnt == '0) begin
                        state       <= S_IDLE;
                        o_field_vld <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_field_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed bench for img_stream_tx: 4x3 frames with H_BLANK=2 (dut_a) and H_BLANK=0 (dut_b).
module tb_img_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic pat_en;

    logic [7:0] mem_a [0:63];
    logic [7:0] mem_b [0:63];
    int wr_a = 0, wr_b = 0;
    int rd_a_p = 0, rd_b_p = 0;
    int hold = 0;
    int stall_at = -1;

    logic       empty_a, empty_b;
    logic [7:0] data_a, data_b;
    logic       rd_a, fv_a, pv_a, busy_a, stall_a;
    logic       rd_b, fv_b, pv_b, busy_b, stall_b;
    logic [7:0] img_a, img_b;

    assign empty_a = (rd_a_p == wr_a) || (hold > 0);
    assign empty_b = (rd_b_p == wr_b);
    assign data_a  = mem_a[rd_a_p[5:0]];
    assign data_b  = mem_b[rd_b_p[5:0]];

    // FIFO models; a pop of word index stall_at starves dut_a for the next 3 cycles.
    always @(posedge clk) begin
        if (rd_a) begin
            rd_a_p <= rd_a_p + 1;
            if (rd_a_p == stall_at) hold <= 3;
        end else if (hold > 0) begin
            hold <= hold - 1;
        end
        if (rd_b) rd_b_p <= rd_b_p + 1;
    end

    img_stream_tx #(.DW(8), .CW(10), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                    .H_BLANK(2), .V_FRONT(1), .V_BACK(1)) dut_a (
        .i_Sys_clk   (clk),
        .i_Rst_n     (rst_n),
        .i_start     (start_a),
`ifdef IMG_STREAM_TX_TEST_PATTERN_EN
        .i_pattern_en(pat_en),
`endif
        .i_fifo_empty(empty_a),
        .i_fifo_data (data_a),
        .o_fifo_rd   (rd_a),
        .o_field_vld (fv_a),
        .o_pixel_vld (pv_a),
        .o_image_data(img_a),
        .o_busy      (busy_a),
        .o_stall     (stall_a)
    );

    img_stream_tx #(.DW(8), .CW(10), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                    .H_BLANK(0), .V_FRONT(1), .V_BACK(1)) dut_b (
        .i_Sys_clk   (clk),
        .i_Rst_n     (rst_n),
        .i_start     (start_b),
`ifdef IMG_STREAM_TX_TEST_PATTERN_EN
        .i_pattern_en(1'b0),
`endif
        .i_fifo_empty(empty_b),
        .i_fifo_data (data_b),
        .o_fifo_rd   (rd_b),
        .o_field_vld (fv_b),
        .o_pixel_vld (pv_b),
        .o_image_data(img_b),
        .o_busy      (busy_b),
        .o_stall     (stall_b)
    );

    int nvec = 0;
    int nerr = 0;

    int          fv_len, stall_n, rd_n, max_run, cur_run, pv_nofv, lead_low, timed_out;
    logic [31:0] pv_bits;
    logic [7:0]  pix [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int sel, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin
                mem_a[wr_a % 64] = 8'(first + i);
                wr_a++;
            end else begin
                mem_b[wr_b % 64] = 8'(first + i);
                wr_b++;
            end
        end
    endtask

    // Samples one field on negedges until field_vld falls; optionally drops start after the first sample.
    task automatic capture(input int sel, input bit drop, input int budget);
        int  c;
        bit  seen;
        logic fv, pv, st, rd;
        logic [7:0] d;
        fv_len = 0; stall_n = 0; rd_n = 0; max_run = 0; cur_run = 0;
        pv_nofv = 0; lead_low = 0; pv_bits = '0; timed_out = 1;
        pix.delete();
        c = 0; seen = 0;
        while (c < budget) begin
            @(negedge clk);
            c++;
            fv = sel ? fv_b : fv_a;
            pv = sel ? pv_b : pv_a;
            st = sel ? stall_b : stall_a;
            rd = sel ? rd_b : rd_a;
            d  = sel ? img_b : img_a;
            if (c == 1 && drop) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (fv) begin
                seen = 1;
                fv_len++;
            end else if (!seen) begin
                lead_low++;
            end
            if (pv && !fv) pv_nofv++;
            if (pv) begin
                pix.push_back(d);
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (st) stall_n++;
            if (rd) rd_n++;
            if (seen) pv_bits = {pv_bits[30:0], pv};
            if (seen && !fv) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic check_pixels(input string tag, input int base);
        check({tag, "_count"}, pix.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check(tag, (i < pix.size()) ? {24'd0, pix[i]} : 32'hFFFF_FFFF, base + i);
        end
    endtask

    int base;
    int n;
    logic [7:0] pat_exp [0:11];

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pat_en  = 1'b0;
        #1;
        check("reset_a", {busy_a, fv_a, pv_a, stall_a, rd_a, img_a}, 0);
        check("reset_b", {busy_b, fv_b, pv_b, stall_b, rd_b, img_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Small frame, FIFO preloaded with 0..11
        push(0, 0, 12);
        start_a = 1'b1;
        capture(0, 1, 200);
        check("small_timeout", timed_out, 0);
        check("small_fv_len", fv_len, 18);
        check("small_pv_shape", pv_bits, 32'h0001_E79E);
        check("small_stall", stall_n, 0);
        check("small_rd", rd_n, 12);
        check("small_pv_nofv", pv_nofv, 0);
        check_pixels("small_pix", 0);

        // Stall: FIFO starves 3 cycles after the second pixel of row 1 (word 12+5)
        push(0, 12, 12);
        stall_at = 17;
        @(negedge clk);
        start_a = 1'b1;
        capture(0, 1, 200);
        stall_at = -1;
        check("stall_timeout", timed_out, 0);
        check("stall_fv_len", fv_len, 21);
        check("stall_pulses", stall_n, 3);
        check("stall_rd", rd_n, 12);
        check_pixels("stall_pix", 12);

        // H_BLANK = 0: back-to-back lines
        push(1, 0, 12);
        @(negedge clk);
        start_b = 1'b1;
        capture(1, 1, 200);
        check("hb0_timeout", timed_out, 0);
        check("hb0_fv_len", fv_len, 14);
        check("hb0_run", max_run, 12);
        check("hb0_stall", stall_n, 0);
        check_pixels("hb0_pix", 0);

        // Start held high through the frame
        push(0, 24, 24);
        @(negedge clk);
        start_a = 1'b1;
        capture(0, 0, 200);
        check("held1_timeout", timed_out, 0);
        check("held1_fv_len", fv_len, 18);
        check_pixels("held1_pix", 24);
        capture(0, 1, 200);
        check("held_gap_extra", lead_low, 0);
        check("held2_timeout", timed_out, 0);
        check("held2_fv_len", fv_len, 18);
        check_pixels("held2_pix", 36);
        repeat (3) @(negedge clk);
        check("held_no_third", {busy_a, fv_a}, 0);

        // Reset during row 1
        push(0, 48, 24);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (rd_a_p < 54 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_row1", (rd_a_p >= 54) ? 1 : 0, 1);
        check("midrst_fv_before", fv_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outs", {busy_a, fv_a, pv_a, stall_a, rd_a, img_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = rd_a_p;
        @(negedge clk);
        start_a = 1'b1;
        capture(0, 1, 200);
        check("midrst_timeout", timed_out, 0);
        check("midrst_fv_len", fv_len, 18);
        check("midrst_rd", rd_n, 12);
        check_pixels("midrst_pix", base);

`ifdef IMG_STREAM_TX_TEST_PATTERN_EN
        // Pattern mode: data = row + col, FIFO left untouched
        pat_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5};
        pat_en = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        capture(0, 1, 200);
        check("pat_timeout", timed_out, 0);
        check("pat_rd", rd_n, 0);
        check("pat_fv_len", fv_len, 18);
        check("pat_count", pix.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check("pat_pix", (i < pix.size()) ? {24'd0, pix[i]} : 32'hFFFF_FFFF, {24'd0, pat_exp[i]});
        end
        pat_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
